// File: rtl/sync_fifo_width_conv_fwft.sv
// Single-clock FWFT FIFO with narrow<->wide width conversion.
// MODE=0 packs narrow writes into wide words (with partial-word flush);
// MODE=1 stores wide writes and serialises them to narrow reads.
module sync_fifo_width_conv_fwft #(
  parameter int NARROW_BYTES = 1,
  parameter int RATIO_LOG2   = 2,
  parameter int DEPTH_LOG2   = 10,
  parameter int MODE         = 0,
  parameter int RESERVE      = 0,
  localparam int NW  = 8 * NARROW_BYTES,
  localparam int WW  = NW * (2 ** RATIO_LOG2),
  localparam int WDW = (MODE != 0) ? WW : NW,
  localparam int RDW = (MODE != 0) ? NW : WW,
  localparam int LW  = RATIO_LOG2 + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WDW-1:0]        wr_data,
  input  logic                  wr_flush,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  rd_en,
  output logic [RDW-1:0]        rd_data,
  output logic [LW-1:0]         rd_lanes,
  output logic                  rd_last,
  output logic                  empty
);

  localparam int unsigned R = 1 << RATIO_LOG2;
  localparam int unsigned D = 1 << DEPTH_LOG2;

  logic [WW+LW-1:0]      mem [D];
  logic [DEPTH_LOG2-1:0] wptr, rptr;

  logic                  push;
  logic [WW-1:0]         push_data;
  logic [LW-1:0]         push_lanes;

  logic                  out_valid;
  logic [WW-1:0]         out_data;
  logic [LW-1:0]         out_lanes;
  logic                  consume;
  logic                  load;

  assign full  = level >= (DEPTH_LOG2 + 1)'(D - RESERVE);
  assign empty = !out_valid;
  assign load  = (level != '0) && (!out_valid || consume);

  generate
    if (MODE == 0) begin : g_pack
      logic [WW-1:0]         pk_data;
      logic [RATIO_LOG2-1:0] k;
      logic [WW-1:0]         acc;
      logic                  flush_go;

      // Packer contents with the current write lane merged in
      always_comb begin
        acc = pk_data;
        if (wr_en) acc[k*NW +: NW] = wr_data;
      end

      assign flush_go   = wr_flush && !full && ((k != '0) || wr_en);
      assign push       = (wr_en && !full && (k == RATIO_LOG2'(R - 1))) || flush_go;
      assign push_data  = acc;
      assign push_lanes = LW'(k) + LW'(wr_en);
      assign consume    = rd_en && out_valid;

      // Lane accumulation; cleared on every storage push so flushed upper lanes read zero
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pk_data <= '0;
          k       <= '0;
        end else if (push) begin
          pk_data <= '0;
          k       <= '0;
        end else if (wr_en && !full) begin
          pk_data <= acc;
          k       <= k + 1'b1;
        end
      end

      assign rd_data  = out_data;
      assign rd_lanes = out_valid ? out_lanes : '0;
      assign rd_last  = out_valid && (out_lanes < LW'(R));
    end else begin : g_unpack
      logic [RATIO_LOG2-1:0] j;
      logic                  last;

      assign push       = wr_en && !full;
      assign push_data  = wr_data;
      assign push_lanes = LW'(R);
      assign last       = (j == RATIO_LOG2'(R - 1));
      assign consume    = rd_en && out_valid && last;

      // Lane index within the wide word held by the output stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           j <= '0;
        else if (load)                        j <= '0;
        else if (rd_en && out_valid && !last) j <= j + 1'b1;
      end

      assign rd_data  = out_data[j*NW +: NW];
      assign rd_lanes = out_valid ? LW'(1) : '0;
      assign rd_last  = out_valid && last;
    end
  endgenerate

  // Storage RAM write port (contents deliberately not reset)
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {push_lanes, push_data};
  end

  // Pointers and occupancy; push and load in one cycle leave level unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (load) rptr <= rptr + 1'b1;
      if (push && !load)      level <= level + 1'b1;
      else if (!push && load) level <= level - 1'b1;
    end
  end

  // FWFT output stage: refills from storage when empty or being fully consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lanes <= '0;
    end else if (load) begin
      out_valid              <= 1'b1;
      {out_lanes, out_data}  <= mem[rptr];
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule
